// File: rtl/pipeline_mem_arbiter_if.sv
// Bundle of the instruction-fetch port, data port and shared memory port of pipeline_mem_arbiter.
// slave: the arbiter's view; master: the environment (fetch unit, LSU and memory).
interface pipeline_mem_arbiter_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
);
    localparam int unsigned SW = DW / 8;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_ack;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ready,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ack, m_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ready,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory, one transaction at a time.
// Define MEM_ARB_FAIR_EN to alternate grants on simultaneous requests; otherwise data always wins ties.
module pipeline_mem_arbiter #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_mem_arbiter_if.slave   bus
);
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

    state_e        state_q, state_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [SW-1:0] m_wstrb_q, m_wstrb_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_ready_q, d_ready_d;
    logic          pick_d, pick_i;
`ifdef MEM_ARB_FAIR_EN
    logic          last_grant_q, last_grant_d;  // 1 = data was granted last
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
            if_rdata_q <= '0;
            if_ready_q <= 1'b0;
            d_rdata_q  <= '0;
            d_ready_q  <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
            if_rdata_q <= if_rdata_d;
            if_ready_q <= if_ready_d;
            d_rdata_q  <= d_rdata_d;
            d_ready_q  <= d_ready_d;
`ifdef MEM_ARB_FAIR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Grant selection, memory-side latching and completion capture
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        if_rdata_d = if_rdata_q;
        if_ready_d = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_ready_d  = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        last_grant_d = last_grant_q;
        pick_d       = bus.d_req && (!bus.if_req || !last_grant_q);
`else
        pick_d       = bus.d_req;
`endif
        pick_i = bus.if_req && !pick_d;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d   = D_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_wstrb_d = bus.d_wstrb;
`ifdef MEM_ARB_FAIR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (pick_i) begin
                    state_d   = I_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.if_addr;
                    m_wdata_d = '0;
                    m_wstrb_d = '0;
`ifdef MEM_ARB_FAIR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            I_BUSY: begin
                if (bus.m_ack) begin
                    state_d    = DONE;
                    m_req_d    = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = m_addr_q[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
                end
            end
            D_BUSY: begin
                if (bus.m_ack) begin
                    state_d   = DONE;
                    m_req_d   = 1'b0;
                    d_ready_d = 1'b1;
                    d_rdata_d = bus.m_rdata;
                end
            end
            DONE: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.m_wstrb  = m_wstrb_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.if_ready = if_ready_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_ready  = d_ready_q;
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed, table-driven bench for pipeline_mem_arbiter; tie-order expectations follow MEM_ARB_FAIR_EN.
module tb_pipeline_mem_arbiter;
    logic clk;
    logic reset;

    pipeline_mem_arbiter_if #(.AW(64), .DW(64)) bus ();

    pipeline_mem_arbiter #(.AW(64), .DW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          wait_n;
        logic        drop;
        logic [63:0] rdata;
        logic [63:0] exp_rd;
    } vec_t;

    int n_vec;
    int n_err;
    logic [63:0] last_if;
    logic [63:0] last_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({bus.m_req, bus.m_we, bus.if_ready, bus.d_ready}), 64'd0);
        chk({tag, "_maddr"}, bus.m_addr, 64'd0);
        chk({tag, "_mwdata"}, bus.m_wdata, 64'd0);
        chk({tag, "_mwstrb"}, 64'(bus.m_wstrb), 64'd0);
        chk({tag, "_ifrdata"}, 64'(bus.if_rdata), 64'd0);
        chk({tag, "_drdata"}, bus.d_rdata, 64'd0);
    endtask

    // One complete transaction: grant edge, wait_n ack-less cycles, ack, DONE, back to IDLE
    task automatic run_txn(input vec_t v);
        logic [7:0] exp_strb;
        exp_strb = v.is_d ? v.wstrb : 8'h00;
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
            bus.d_wdata = v.wdata; bus.d_wstrb = v.wstrb;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        tick();
        chk("grant_m_req", 64'(bus.m_req), 64'd1);
        chk("grant_m_addr", bus.m_addr, v.addr);
        chk("grant_m_we_strb", 64'({bus.m_we, bus.m_wstrb}), 64'({v.is_d & v.we, exp_strb}));
        if (v.is_d) chk("grant_m_wdata", bus.m_wdata, v.wdata);
        if (v.drop) begin
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
        end
        for (int w = 0; w < v.wait_n; w++) begin
            bus.m_ack = 1'b0;
            tick();
            chk("busy_hold_ctl", 64'({bus.m_req, bus.m_we, bus.m_wstrb, bus.if_ready, bus.d_ready}),
                64'({1'b1, v.is_d & v.we, exp_strb, 1'b0, 1'b0}));
            chk("busy_hold_addr", bus.m_addr, v.addr);
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = v.rdata;
        tick();
        bus.m_ack   = 1'b0;
        bus.m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        chk("done_m_req", 64'(bus.m_req), 64'd0);
        chk("done_ready", 64'({bus.if_ready, bus.d_ready}), 64'({!v.is_d, v.is_d}));
        if (v.is_d) begin
            chk("done_d_rdata", bus.d_rdata, v.exp_rd);
            chk("other_if_rdata_hold", 64'(bus.if_rdata), last_if);
            last_d = v.exp_rd;
        end else begin
            chk("done_if_rdata", 64'(bus.if_rdata), v.exp_rd);
            chk("other_d_rdata_hold", bus.d_rdata, last_d);
            last_if = v.exp_rd;
        end
        tick();
        chk("after_done_ready", 64'({bus.if_ready, bus.d_ready, bus.m_req}), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic exp_side;
        n_vec   = 0;
        n_err   = 0;
        last_if = '0;
        last_d  = '0;

        //          is_d  we    addr                   wdata                  wstrb  wait drop  m_rdata                exp
        vecs[0] = '{1'b0, 1'b0, 64'h1004,              64'h0,                 8'h00, 2,   1'b0, 64'hAABBCCDD_11223344, 64'hAABBCCDD};
        vecs[1] = '{1'b0, 1'b0, 64'h1000,              64'h0,                 8'h00, 0,   1'b0, 64'hAABBCCDD_11223344, 64'h11223344};
        vecs[2] = '{1'b1, 1'b1, 64'h2000,              64'h55,                8'h01, 0,   1'b0, 64'h0000_0000_0000_DEAD, 64'h0000_0000_0000_DEAD};
        vecs[3] = '{1'b1, 1'b0, 64'h3008,              64'h0,                 8'h00, 10,  1'b0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF};
        vecs[4] = '{1'b0, 1'b0, 64'h1FFC,              64'h0,                 8'h00, 1,   1'b1, 64'hCAFEF00D_00000000, 64'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b1, 64'hFFFF_0000_0000_2003, 64'hFFEE_DDCC_BBAA_9988, 8'hF0, 3, 1'b1, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Acks while IDLE must be ignored
        bus.m_ack   = 1'b1;
        bus.m_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        tick();
        tick();
        chk("idle_ack_ignored", 64'({bus.m_req, bus.if_ready, bus.d_ready}), 64'd0);
        chk("idle_ack_rdata", bus.d_rdata, 64'd0);
        bus.m_ack = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Simultaneous requests held across four transactions
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_if = '0;
        last_d  = '0;
        bus.if_req = 1'b1; bus.if_addr = 64'h1004;
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h4000;
        bus.d_wdata = '0; bus.d_wstrb = '0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FAIR_EN
            exp_side = (k % 2 == 0);
`else
            exp_side = 1'b1;
`endif
            tick();
            chk("tie_m_req", 64'(bus.m_req), 64'd1);
            chk("tie_winner", 64'(bus.m_addr == 64'h4000), 64'(exp_side));
            bus.m_ack   = 1'b1;
            bus.m_rdata = 64'hAABBCCDD_11223344;
            tick();
            bus.m_ack = 1'b0;
            chk("tie_ready", 64'({bus.if_ready, bus.d_ready}), 64'({!exp_side, exp_side}));
            tick();
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
        tick();

        // Reset during D_BUSY abandons the transaction; a late ack is ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h5000;
        bus.d_wdata = 64'h77; bus.d_wstrb = 8'hFF;
        tick();
        chk("midrst_busy", 64'(bus.m_req), 64'd1);
        tick();
        reset = 1'b1;
        bus.d_req = 1'b0;
        #1;
        chk_reset_outputs("midrst_async");
        tick();
        reset = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 64'h9999_9999_9999_9999;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midrst_no_ready", 64'({bus.m_req, bus.d_ready, bus.if_ready}), 64'd0);
            chk("midrst_drdata", bus.d_rdata, 64'd0);
        end
        bus.m_ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
